fp16_norm_round: RTL

- Post-add normalise-and-round stage for the half-precision adder datapath (1 sign, 5 exponent, 10 mantissa bits).
- Consumes the raw sign, exponent and extended significand produced by the adder's align/add step.
- Normalises iteratively, rounds to nearest-even, and emits the packed result with overflow/underflow flags.
- Valid/ready handshake on both sides; one operation in flight at a time.

---
 rtl/fp16_pkg.sv | 43 ++++
 rtl/fp16_lzc.sv | 17 +
 rtl/fp16_norm_round.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fp16_pkg.sv
// Shared widths, raw-significand bit positions, FSM encoding and small helpers
// for the half-precision normalise-and-round stage.
package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int MAN_W  = 10;
  localparam int RAW_W  = MAN_W + 5;
  // Internal exponent: two extra bits so carries above 31 and shifts below 0 stay visible.
  localparam int EXP_IW = EXP_W + 2;
  localparam int LZC_W  = 4;

  localparam int CARRY_BIT = 14;
  localparam int HID_BIT   = 13;
  localparam int MAN_HI    = 12;
  localparam int MAN_LO    = 3;
  localparam int G_BIT     = 2;
  localparam int R_BIT     = 1;
  localparam int S_BIT     = 0;

  localparam logic [EXP_IW-2:0] EXP_MAX = 6'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Round-to-nearest-even increment: above half, or exactly half with odd lsb.
  function automatic logic rne_inc(input logic [RAW_W-1:0] raw);
    return raw[G_BIT] & (raw[R_BIT] | raw[S_BIT] | raw[MAN_LO]);
  endfunction

  // Internal exponent is two's complement; these avoid signed-compare surprises.
  function automatic logic exp_le_zero(input logic [EXP_IW-1:0] e);
    return e[EXP_IW-1] || (e == '0);
  endfunction

  function automatic logic exp_ge_max(input logic [EXP_IW-1:0] e);
    return !e[EXP_IW-1] && (e[EXP_IW-2:0] >= EXP_MAX);
  endfunction

endpackage

// File: rtl/fp16_lzc.sv
// Leading-zero counter over the 15-bit raw significand (count 15 for an all-zero word).
module fp16_lzc
  import fp16_pkg::*;
(
  input  logic [RAW_W-1:0] value,
  output logic [LZC_W-1:0] count
);

  // Ascending scan: the highest set bit is the last one to write the count.
  always_comb begin
    count = LZC_W'(RAW_W);
    for (int i = 0; i < RAW_W; i++) begin
      if (value[i]) count = LZC_W'(RAW_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp16_norm_round.sv
// Post-add normalise/round stage for fp16: IDLE -> NORM -> ROUND -> OUT, one op in flight.
// Define FP16_NORM_LZC_EN to replace the bit-serial left shift with a one-cycle LZC shift.
module fp16_norm_round
  import fp16_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_Sign,
  input  logic [EXP_W-1:0] in_Exponent,
  input  logic [RAW_W-1:0] in_Raw,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_Sign,
  output logic [EXP_W-1:0] out_Exponent,
  output logic [MAN_W-1:0] out_Mantissa,
  output logic             out_OverFlow,
  output logic             out_UnderFlow,
  output state_t           dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; out_valid and the data outputs then stay frozen until out_ready is seen.

  state_t              state, state_n;
  logic                sign_q, sign_n;
  logic [EXP_IW-1:0]   exp_q, exp_n;
  logic [RAW_W-1:0]    raw_q, raw_n;
  logic                zero_q, zero_n;
  logic                uf_q, uf_n;

  logic                o_sign_n, o_of_n, o_uf_n, o_valid_n;
  logic [EXP_W-1:0]    o_exp_n;
  logic [MAN_W-1:0]    o_man_n;

  logic [MAN_W:0]      man_sum;
  logic [EXP_IW-1:0]   exp_rnd;
  logic [EXP_IW-1:0]   exp_dec;

`ifdef FP16_NORM_LZC_EN
  logic [LZC_W-1:0]    lz;
  logic [LZC_W-1:0]    shift_amt;
  logic [EXP_IW-1:0]   exp_shift;

  fp16_lzc u_lzc (
    .value (raw_q),
    .count (lz)
  );

  // Only used when neither carry nor hidden is set, so lz is at least 2 here.
  assign shift_amt = lz - LZC_W'(1);
  assign exp_shift = exp_q - {{(EXP_IW-LZC_W){1'b0}}, shift_amt};
`endif

  assign in_ready  = (state == IDLE);
  assign dbg_state = state;

  always_comb begin
    state_n   = state;
    sign_n    = sign_q;
    exp_n     = exp_q;
    raw_n     = raw_q;
    zero_n    = zero_q;
    uf_n      = uf_q;
    o_sign_n  = out_Sign;
    o_exp_n   = out_Exponent;
    o_man_n   = out_Mantissa;
    o_of_n    = out_OverFlow;
    o_uf_n    = out_UnderFlow;
    o_valid_n = out_valid;

    man_sum = {1'b0, raw_q[MAN_HI:MAN_LO]} + {{MAN_W{1'b0}}, rne_inc(raw_q)};
    exp_rnd = exp_q + {{(EXP_IW-1){1'b0}}, man_sum[MAN_W]};
    exp_dec = exp_q - {{(EXP_IW-1){1'b0}}, 1'b1};

    case (state)
      IDLE: begin
        if (in_valid) begin
          sign_n  = in_Sign;
          exp_n   = {2'b00, in_Exponent};
          raw_n   = in_Raw;
          zero_n  = 1'b0;
          uf_n    = 1'b0;
          state_n = NORM;
        end
      end

      NORM: begin
        if (raw_q == '0) begin
          zero_n  = 1'b1;
          state_n = ROUND;
        end else if (raw_q[CARRY_BIT]) begin
          raw_n = {1'b0, raw_q[RAW_W-1:2], raw_q[R_BIT] | raw_q[S_BIT]};
          exp_n = exp_q + {{(EXP_IW-1){1'b0}}, 1'b1};
`ifdef FP16_NORM_LZC_EN
          state_n = ROUND;
`else
          // Right shift counts as a shift cycle; the next NORM pass sees hidden=1.
          state_n = NORM;
`endif
        end else if (raw_q[HID_BIT]) begin
          state_n = ROUND;
        end else begin
`ifdef FP16_NORM_LZC_EN
          if (exp_le_zero(exp_shift)) begin
            uf_n = 1'b1;
          end else begin
            raw_n = raw_q << shift_amt;
            exp_n = exp_shift;
          end
          state_n = ROUND;
`else
          raw_n = raw_q << 1;
          exp_n = exp_dec;
          if (exp_le_zero(exp_dec)) begin
            uf_n    = 1'b1;
            state_n = ROUND;
          end
`endif
        end
      end

      ROUND: begin
        o_sign_n  = sign_q;
        o_valid_n = 1'b1;
        state_n   = OUT;
        if (zero_q || uf_q) begin
          o_exp_n = '0;
          o_man_n = '0;
          o_of_n  = 1'b0;
          o_uf_n  = uf_q;
        end else if (exp_ge_max(exp_rnd)) begin
          o_exp_n = '1;
          o_man_n = '0;
          o_of_n  = 1'b1;
          o_uf_n  = 1'b0;
        end else begin
          o_exp_n = exp_rnd[EXP_W-1:0];
          o_man_n = man_sum[MAN_W-1:0];
          o_of_n  = 1'b0;
          o_uf_n  = 1'b0;
        end
      end

      OUT: begin
        if (out_ready) begin
          o_valid_n = 1'b0;
          state_n   = IDLE;
        end
      end

      default: begin
        state_n   = IDLE;
        o_valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sign_q        <= 1'b0;
      exp_q         <= '0;
      raw_q         <= '0;
      zero_q        <= 1'b0;
      uf_q          <= 1'b0;
      out_valid     <= 1'b0;
      out_Sign      <= 1'b0;
      out_Exponent  <= '0;
      out_Mantissa  <= '0;
      out_OverFlow  <= 1'b0;
      out_UnderFlow <= 1'b0;
    end else begin
      state         <= state_n;
      sign_q        <= sign_n;
      exp_q         <= exp_n;
      raw_q         <= raw_n;
      zero_q        <= zero_n;
      uf_q          <= uf_n;
      out_valid     <= o_valid_n;
      out_Sign      <= o_sign_n;
      out_Exponent  <= o_exp_n;
      out_Mantissa  <= o_man_n;
      out_OverFlow  <= o_of_n;
      out_UnderFlow <= o_uf_n;
    end
  end

endmodule
